// File: rtl/mm_host_pkg.sv
// Shared constants, state encoding and byte-placement helper for the mm_host
// UART initiator and its serial link.
package mm_host_pkg;

    localparam int N          = 4;
    localparam int ELEMS      = N * N;
    localparam int TX_BYTES   = 2 * ELEMS;
    localparam int RX_BYTES   = 2 * ELEMS;
    localparam int FRAME_BITS = 11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SEND   = 2'd1;
    localparam state_t ST_RECV   = 2'd2;
    localparam state_t ST_FINISH = 2'd3;

    // Result words arrive high byte first: even RX byte -> upper half of word idx/2.
    function automatic logic [7:0] rx_byte_offset(input logic [4:0] idx);
        return {idx[4:1], ~idx[0], 3'b000};
    endfunction

endpackage

// File: rtl/mm_uart_link.sv
// Byte-level UART link: 11-bit-period TX frames (start, 8 data, stop, idle)
// and a synchronised, mid-bit-sampling RX with false-start rejection.
module mm_uart_link import mm_host_pkg::*; #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_line,
    input  logic       rx_en,
    input  logic       rx_line,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       rx_start
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    TX_LAST   = 4'(FRAME_BITS - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic          tx_active;
    logic [CW-1:0] tx_clk;
    logic [3:0]    tx_bit;
    logic [9:0]    tx_shift;
    logic          tx_bit_end;
    logic          tx_take;

    // Ready during the final cycle of a frame so frames run back to back.
    assign tx_bit_end = (tx_clk == BIT_LAST);
    assign tx_ready   = !tx_active || (tx_bit_end && tx_bit == TX_LAST);
    assign tx_take    = tx_valid && tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_active <= 1'b0;
            tx_line   <= 1'b1;
            tx_clk    <= '0;
            tx_bit    <= '0;
        end else if (tx_take) begin
            tx_active <= 1'b1;
            tx_line   <= 1'b0;
            tx_clk    <= '0;
            tx_bit    <= '0;
        end else if (tx_active) begin
            if (tx_bit_end) begin
                tx_clk <= '0;
                if (tx_bit == TX_LAST) begin
                    tx_active <= 1'b0;
                    tx_line   <= 1'b1;
                end else begin
                    tx_bit  <= tx_bit + 4'd1;
                    tx_line <= tx_shift[0];
                end
            end else begin
                tx_clk <= tx_clk + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_take)
            tx_shift <= {2'b11, tx_data};
        else if (tx_active && tx_bit_end && tx_bit != TX_LAST)
            tx_shift <= {1'b1, tx_shift[9:1]};
    end

    logic          rx_s1, rx_s2, rx_prev;
    logic [1:0]    rx_state;
    logic [CW-1:0] rx_clk;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_mid;

    assign rx_mid = (rx_clk == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_clk   <= '0;
            rx_bit   <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            rx_start <= 1'b0;
        end else begin
            rx_s1    <= rx_line;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            rx_start <= 1'b0;
            if (!rx_en) begin
                rx_state <= RX_IDLE;
            end else begin
                case (rx_state)
                    RX_IDLE: begin
                        if (rx_prev && !rx_s2) begin
                            rx_state <= RX_START;
                            rx_clk   <= '0;
                        end
                    end
                    RX_START: begin
                        if (rx_clk == HALF_LAST) begin
                            rx_clk <= '0;
                            if (rx_s2) begin
                                rx_state <= RX_IDLE;
                            end else begin
                                rx_state <= RX_DATA;
                                rx_bit   <= '0;
                                rx_start <= 1'b1;
                            end
                        end else begin
                            rx_clk <= rx_clk + CW'(1);
                        end
                    end
                    RX_DATA: begin
                        if (rx_mid) begin
                            rx_clk <= '0;
                            rx_bit <= rx_bit + 3'd1;
                            if (rx_bit == 3'd7)
                                rx_state <= RX_STOP;
                        end else begin
                            rx_clk <= rx_clk + CW'(1);
                        end
                    end
                    RX_STOP: begin
                        if (rx_mid) begin
                            rx_clk   <= '0;
                            rx_state <= RX_IDLE;
                            if (rx_s2)
                                rx_valid <= 1'b1;
                            else
                                rx_err <= 1'b1;
                        end else begin
                            rx_clk <= rx_clk + CW'(1);
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == RX_DATA && rx_mid)
            rx_shift <= {rx_s2, rx_shift[7:1]};
        if (rx_state == RX_STOP && rx_mid)
            rx_data <= rx_shift;
    end

endmodule

// File: rtl/mm_host.sv
// Host-side initiator: serialises A and B to the matrix-multiply accelerator,
// collects the sixteen 16-bit results and reports them with a start/done handshake.
module mm_host import mm_host_pkg::*; #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int TIMEOUT_BITS = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*ELEMS-1:0]    a_flat,
    input  logic [8*ELEMS-1:0]    b_flat,
    output logic [16*ELEMS-1:0]   c_flat,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  UART_TX,
    input  logic                  UART_RX
);

    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW       = $clog2(TO_LIMIT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT - 1);

    state_t                 state;
    logic [5:0]             tx_idx;
    logic [4:0]             rx_idx;
    logic [TW-1:0]          to_cnt;
    logic [8*TX_BYTES-1:0]  tx_buf;
    logic [16*ELEMS-1:0]    shadow;
    logic [16*ELEMS-1:0]    shadow_next;
    logic [7:0]             rx_off;
    logic [7:0]             tx_data;
    logic [7:0]             rx_data;
    logic                   tx_valid, tx_ready;
    logic                   rx_en, rx_valid, rx_err, rx_start;

    // Byte 0 is offered straight from a_flat so the start bit leaves on the accepting edge.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = a_flat[7:0];
        if (state == ST_IDLE) begin
            tx_valid = start;
        end else if (state == ST_SEND) begin
            tx_valid = (tx_idx < 6'(TX_BYTES));
            tx_data  = tx_buf[{tx_idx[4:0], 3'b000} +: 8];
        end
    end

    assign rx_en  = (state == ST_RECV);
    assign rx_off = rx_byte_offset(rx_idx);

    always_comb begin
        shadow_next = shadow;
        shadow_next[rx_off +: 8] = rx_data;
    end

    mm_uart_link #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_link (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_line  (UART_TX),
        .rx_en    (rx_en),
        .rx_line  (UART_RX),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .rx_start (rx_start)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            tx_idx <= '0;
            rx_idx <= '0;
            to_cnt <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            c_flat <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_SEND;
                        tx_idx <= 6'd1;
                        rx_idx <= '0;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (tx_valid && tx_ready)
                        tx_idx <= tx_idx + 6'd1;
                    if (tx_idx == 6'(TX_BYTES) && tx_ready) begin
                        state  <= ST_RECV;
                        to_cnt <= '0;
                    end
                end
                ST_RECV: begin
                    to_cnt <= rx_start ? '0 : to_cnt + TW'(1);
                    if (rx_err || (!rx_valid && to_cnt == TO_LAST)) begin
                        state <= ST_FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (rx_valid) begin
                        if (rx_idx == 5'(RX_BYTES - 1)) begin
                            state  <= ST_FINISH;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            c_flat <= shadow_next;
                        end else begin
                            rx_idx <= rx_idx + 5'd1;
                        end
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start)
            tx_buf <= {b_flat, a_flat};
        if (rx_en && rx_valid)
            shadow <= shadow_next;
    end

endmodule

// File: tb/tb_mm_host.sv
// Bench for mm_host: a behavioural accelerator peer decodes the TX stream,
// multiplies the received matrices and answers over UART_RX.
module tb_mm_host;

    localparam int CPB = 16;
    localparam int TOB = 50;
    localparam int NB  = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] a_flat, b_flat;
    logic [255:0] c_flat;
    logic         busy, done, err, uart_tx, uart_rx;

    int     n_chk = 0;
    int     n_pass = 0;
    longint cyc = 0;
    int     done_cnt = 0;
    longint done_at = 0;
    logic   busy_at_done = 1'b1;
    logic [7:0] txq[$];

    always #5 clk = ~clk;

    mm_host #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_flat  (a_flat),
        .b_flat  (b_flat),
        .c_flat  (c_flat),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .UART_TX (uart_tx),
        .UART_RX (uart_rx)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt     <= done_cnt + 1;
            done_at      <= cyc;
            busy_at_done <= busy;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Golden product, element (i,j) = sum_m A[i][m]*B[m][j] mod 2^16.
    function automatic logic [255:0] mat_mul(input logic [127:0] a, input logic [127:0] b);
        logic [255:0] r;
        int unsigned s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int m = 0; m < 4; m++)
                    s += 32'(a[(i*4+m)*8 +: 8]) * 32'(b[(m*4+j)*8 +: 8]);
                r[(i*4+j)*16 +: 16] = s[15:0];
            end
        end
        return r;
    endfunction

    task automatic collect_tx(output bit ok);
        logic [7:0] d;
        int w;
        ok = 1'b1;
        txq.delete();
        for (int i = 0; i < NB; i++) begin
            w = 0;
            while (uart_tx !== 1'b0 && w < 40*CPB) begin
                @(negedge clk);
                w++;
            end
            if (w >= 40*CPB) begin
                ok = 1'b0;
                return;
            end
            repeat (CPB/2) @(negedge clk);
            for (int b = 0; b < 8; b++) begin
                repeat (CPB) @(negedge clk);
                d[b] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            if (uart_tx !== 1'b1) ok = 1'b0;
            txq.push_back(d);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            uart_rx = d[b];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    // mode 0: normal, 1: stop bit of byte 5 low, 2: glitch + start pulse in RECV
    task automatic reply(input int mode, input int d0);
        logic [127:0] ra, rb;
        logic [255:0] rc;
        logic [7:0]   x;
        int k, g;
        for (int i = 0; i < 16; i++) begin
            ra[8*i +: 8] = txq[i];
            rb[8*i +: 8] = txq[16+i];
        end
        rc = mat_mul(ra, rb);
        repeat (2*CPB) @(negedge clk);
        if (mode == 2) begin
            uart_rx = 1'b0;
            @(negedge clk);
            uart_rx = 1'b1;
            repeat (3*CPB) @(negedge clk);
        end
        for (int j = 0; j < NB; j++) begin
            k = j / 2;
            x = (j % 2 == 0) ? rc[k*16+8 +: 8] : rc[k*16 +: 8];
            if (mode == 1 && j == 5) begin
                check("frame_no_early_done", 256'(done_cnt - d0), 256'(0));
                send_byte(x, 1'b0);
                @(negedge clk);
                check("frame_prompt_done", 256'(done_cnt - d0), 256'(1));
                return;
            end
            send_byte(x, 1'b1);
            if (mode == 2 && j == 10) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            g = int'($urandom_range(2));
            repeat (g*CPB) @(negedge clk);
        end
    endtask

    // mode 3: silent peer
    task automatic run_txn(input logic [127:0] a, input logic [127:0] b, input int mode, input string tag);
        logic [255:0] prev_c, got_tx, exp_c;
        int d0;
        bit ok, seen;
        longint t0;
        prev_c = c_flat;
        d0     = done_cnt;
        exp_c  = mat_mul(a, b);
        @(negedge clk);
        a_flat = a;
        b_flat = b;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
        check({tag, "_busy_c1"}, 256'(busy), 256'(1));
        check({tag, "_tx_c1"}, 256'(uart_tx), 256'(0));
        check({tag, "_err_c1"}, 256'(err), 256'(0));
        fork
            collect_tx(ok);
            begin
                if (mode == 2) begin
                    repeat (50*CPB) @(negedge clk);
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        join
        check({tag, "_tx_frames"}, 256'(ok), 256'(1));
        got_tx = '0;
        for (int i = 0; i < txq.size() && i < NB; i++) got_tx[8*i +: 8] = txq[i];
        check({tag, "_tx_bytes"}, got_tx, {b, a});
        if (mode != 3 && ok) reply(mode, d0);
        wait_done(d0, 3*TOB*CPB, seen);
        check({tag, "_done_seen"}, 256'(seen), 256'(1));
        check({tag, "_busy_at_done"}, 256'(busy_at_done), 256'(0));
        if (mode == 3) begin
            check({tag, "_timeout_lat"}, 256'(done_at - t0), 256'(NB*11*CPB + TOB*CPB));
            check({tag, "_err"}, 256'(err), 256'(1));
            check({tag, "_c_kept"}, c_flat, prev_c);
        end else if (mode == 1) begin
            check({tag, "_err"}, 256'(err), 256'(1));
            check({tag, "_c_kept"}, c_flat, prev_c);
        end else begin
            check({tag, "_err"}, 256'(err), 256'(0));
            check({tag, "_c"}, c_flat, exp_c);
        end
        repeat (4*CPB) @(negedge clk);
        check({tag, "_one_done"}, 256'(done_cnt - d0), 256'(1));
        check({tag, "_idle_after"}, 256'(busy), 256'(0));
    endtask

    task automatic wait_done(input int prev, input int budget, output bit seen);
        int w;
        w = 0;
        seen = 1'b0;
        while (w < budget) begin
            @(negedge clk);
            w++;
            if (done_cnt > prev) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a, b;
        logic [255:0] v;
        rst     = 1'b1;
        start   = 1'b0;
        uart_rx = 1'b1;
        a_flat  = '0;
        b_flat  = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", 256'(uart_tx), 256'(1));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        check("rst_c", c_flat, 256'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 16; k++) begin
            a[8*k +: 8] = (k % 5 == 0) ? 8'd1 : 8'd0;
            b[8*k +: 8] = 8'(k + 1);
            v[16*k +: 16] = 16'(k + 1);
        end
        run_txn(a, b, 2, "ident");
        check("ident_c_const", c_flat, v);

        run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 3, "silent");
        run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1, "frame");
        run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, "recover");

        a = {$urandom, $urandom, $urandom, $urandom} & ~128'hFF;
        @(negedge clk);
        a_flat = a;
        b_flat = '1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("midsend_tx_low", 256'(uart_tx), 256'(0));
        #2 rst = 1'b1;
        #1;
        check("midsend_rst_tx", 256'(uart_tx), 256'(1));
        check("midsend_rst_busy", 256'(busy), 256'(0));
        check("midsend_rst_c", c_flat, 256'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_txn('1, '1, 0, "sat");
        check("sat_c_const", c_flat, {16{16'hF804}});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
